// File: rtl/demux3_pkg.sv
// rtl/demux3_pkg.sv - route/state types and select decode for demux3_stream
package demux3_pkg;

  typedef enum logic [1:0] {
    ROUTE0 = 2'd0,
    ROUTE1 = 2'd1,
    ROUTE2 = 2'd2
  } route_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } dstate_t;

  // Same encoding as the 3:1 mux: 10 and 11 both select port2.
  function automatic route_t decode_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   return ROUTE0;
      2'b01:   return ROUTE1;
      default: return ROUTE2;
    endcase
  endfunction

endpackage

// File: rtl/stream_slot.sv
// rtl/stream_slot.sv - one-entry output register with valid/ready and packet counter
module stream_slot #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNTW-1:0]  pkt_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      // A load wins over a drain, so drain+load keeps y_valid high.
      if (load) begin
        y_valid <= 1'b1;
        y_data  <= load_data;
        y_last  <= load_last;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
      if (y_valid && y_ready && y_last)
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux3_stream.sv
// rtl/demux3_stream.sv - 1:3 packet-locked stream demultiplexer with registered outputs
module demux3_stream
  import demux3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y0_data,
  output logic [WIDTH-1:0] y1_data,
  output logic [WIDTH-1:0] y2_data,
  output logic             y0_last,
  output logic             y1_last,
  output logic             y2_last,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic             y2_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  input  logic             y2_ready,
  output logic [CNTW-1:0]  pkt_cnt0,
  output logic [CNTW-1:0]  pkt_cnt1,
  output logic [CNTW-1:0]  pkt_cnt2
);

  dstate_t    state, state_nxt;
  route_t     route_q, route_eff;
  logic       accept;
  logic [2:0] load, slot_valid, slot_ready;

  assign slot_valid = {y2_valid, y1_valid, y0_valid};
  assign slot_ready = {y2_ready, y1_ready, y0_ready};
  assign route_eff  = (state == IDLE) ? decode_sel(s) : route_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      route_q <= ROUTE0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept && !in_last)
        route_q <= route_eff;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nxt = LOCKED;
      LOCKED:  if (accept && in_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the effective route's slot may stall the producer.
  always_comb begin
    in_ready = 1'b0;
    load     = 3'b000;
    case (route_eff)
      ROUTE0:  in_ready = !slot_valid[0] || slot_ready[0];
      ROUTE1:  in_ready = !slot_valid[1] || slot_ready[1];
      default: in_ready = !slot_valid[2] || slot_ready[2];
    endcase
    accept = in_valid && in_ready;
    case (route_eff)
      ROUTE0:  load[0] = accept;
      ROUTE1:  load[1] = accept;
      default: load[2] = accept;
    endcase
  end

  stream_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .load(load[0]), .load_data(in_data), .load_last(in_last),
    .y_data(y0_data), .y_last(y0_last), .y_valid(y0_valid), .y_ready(y0_ready),
    .pkt_cnt(pkt_cnt0)
  );

  stream_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .load(load[1]), .load_data(in_data), .load_last(in_last),
    .y_data(y1_data), .y_last(y1_last), .y_valid(y1_valid), .y_ready(y1_ready),
    .pkt_cnt(pkt_cnt1)
  );

  stream_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot2 (
    .clk(clk), .rst_n(rst_n), .load(load[2]), .load_data(in_data), .load_last(in_last),
    .y_data(y2_data), .y_last(y2_last), .y_valid(y2_valid), .y_ready(y2_ready),
    .pkt_cnt(pkt_cnt2)
  );

endmodule

// File: tb/tb_demux3_stream.sv
// tb/tb_demux3_stream.sv - randomized and directed bench for demux3_stream against a queue model
module tb_demux3_stream;

  localparam int WIDTH = 8;
  localparam int CNTW  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       s = 2'b00;
  logic [WIDTH-1:0] y0_data, y1_data, y2_data;
  logic             y0_last, y1_last, y2_last;
  logic             y0_valid, y1_valid, y2_valid;
  logic             y0_ready = 1'b1, y1_ready = 1'b1, y2_ready = 1'b1;
  logic [CNTW-1:0]  pkt_cnt0, pkt_cnt1, pkt_cnt2;

  demux3_stream #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .s(s),
    .y0_data(y0_data), .y1_data(y1_data), .y2_data(y2_data),
    .y0_last(y0_last), .y1_last(y1_last), .y2_last(y2_last),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid),
    .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  // Each port's queue holds the beat expected on its output register (0 or 1 entries).
  beat_t q[3][$];
  int    cnt[3];
  bit    in_pkt;
  int    cur_port;
  int    vectors = 0;
  int    miscompares = 0;

  logic [2:0]       yv, yl;
  logic [WIDTH-1:0] yd[3];
  logic [CNTW-1:0]  yc[3];
  assign yv = {y2_valid, y1_valid, y0_valid};
  assign yl = {y2_last, y1_last, y0_last};
  assign yd[0] = y0_data;
  assign yd[1] = y1_data;
  assign yd[2] = y2_data;
  assign yc[0] = pkt_cnt0;
  assign yc[1] = pkt_cnt1;
  assign yc[2] = pkt_cnt2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("y%0d_valid", k), 32'(yv[k]), 32'(q[k].size() != 0));
      if (q[k].size() != 0) begin
        chk($sformatf("y%0d_data", k), 32'(yd[k]), 32'(q[k][0].d));
        chk($sformatf("y%0d_last", k), 32'(yl[k]), 32'(q[k][0].l));
      end
      chk($sformatf("pkt_cnt%0d", k), 32'(yc[k]), 32'(cnt[k]));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      cnt[k] = 0;
    end
    in_pkt = 1'b0;
    cur_port = 0;
  endtask

  // Drive one cycle of inputs, check outputs, advance the model across the clock edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit l, input logic [1:0] sel,
                      input bit r0, input bit r1, input bit r2);
    int    port;
    bit    rdy_exp;
    bit    rdy[3];
    beat_t b;
    in_valid = v; in_data = d; in_last = l; s = sel;
    y0_ready = r0; y1_ready = r1; y2_ready = r2;
    rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
    #1;
    check_outputs();
    port    = in_pkt ? cur_port : ((sel == 2'b00) ? 0 : (sel == 2'b01) ? 1 : 2);
    rdy_exp = (q[port].size() == 0) || rdy[port];
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    for (int k = 0; k < 3; k++) begin
      if (q[k].size() != 0 && rdy[k]) begin
        b = q[k].pop_front();
        if (b.l) cnt[k] = (cnt[k] + 1) % (1 << CNTW);
      end
    end
    if (v && rdy_exp) begin
      b.d = d;
      b.l = l;
      q[port].push_back(b);
      if (!in_pkt && !l) begin
        in_pkt   = 1'b1;
        cur_port = port;
      end else if (in_pkt && l) begin
        in_pkt = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r0, input bit r1, input bit r2);
    step(1'b0, '0, 1'b0, 2'b00, r0, r1, r2);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_y%0d_valid", k), 32'(yv[k]), 32'd0);
      chk($sformatf("rst_pkt_cnt%0d", k), 32'(yc[k]), 32'd0);
    end
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    idle(1, 1, 1);

    // single-beat routing through every select code
    step(1, 8'hA0, 1, 2'b00, 1, 1, 1);
    step(1, 8'hA1, 1, 2'b01, 1, 1, 1);
    step(1, 8'hA2, 1, 2'b10, 1, 1, 1);
    step(1, 8'hA3, 1, 2'b11, 1, 1, 1);
    idle(1, 1, 1);
    idle(1, 1, 1);
    chk("t2_pkt_cnt2", 32'(pkt_cnt2), 32'd2);

    // route stays locked while s changes mid-packet
    step(1, 8'h11, 0, 2'b01, 1, 1, 1);
    step(1, 8'h22, 0, 2'b10, 1, 1, 1);
    step(1, 8'h33, 1, 2'b10, 1, 1, 1);
    idle(1, 1, 1);
    idle(1, 1, 1);
    chk("t3_pkt_cnt1", 32'(pkt_cnt1), 32'd2);

    // backpressure on port0, then back-to-back release
    step(1, 8'h44, 0, 2'b00, 0, 1, 1);
    step(1, 8'h55, 1, 2'b10, 0, 1, 1);
    step(1, 8'h55, 1, 2'b10, 0, 1, 1);
    step(1, 8'h55, 1, 2'b10, 1, 1, 1);
    idle(1, 1, 1);
    idle(1, 1, 1);

    // port2 stalled while port1 takes a packet
    step(1, 8'h66, 1, 2'b10, 1, 1, 0);
    step(1, 8'h77, 0, 2'b01, 1, 1, 0);
    step(1, 8'h88, 1, 2'b11, 1, 1, 0);
    idle(1, 1, 0);
    idle(1, 1, 1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) == 0,
           2'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) != 0);
    end

    // reset in the middle of a stalled packet
    step(1, 8'h99, 0, 2'b01, 0, 0, 0);
    step(1, 8'h9A, 0, 2'b00, 0, 0, 0);
    do_reset();
    idle(1, 1, 1);

    // counter wrap with a 2-bit counter: 1,2,3,0,1
    for (int i = 0; i < 5; i++) step(1, WIDTH'(8'hC0 + i), 1, 2'b00, 1, 1, 1);
    idle(1, 1, 1);
    idle(1, 1, 1);
    chk("wrap_pkt_cnt0", 32'(pkt_cnt0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
